oc_button_input: RTL and testbench



---
 rtl/oc_button_pkg.sv | 21 ++
 rtl/oc_button_input_chan.sv | 151 +++++++++++++++
 rtl/oc_button_input.sv | 42 ++++
 tb/tb_oc_button_input.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oc_button_pkg.sv
// Shared types and helpers for the pushbutton conditioning block.
package oc_button_pkg;

  // Per-channel debounce/long-press state.
  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_PEND   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_HELD_LONG    = 3'd3,
    ST_RELEASE_PEND = 3'd4
  } button_state_e;

  // Counter width wide enough to hold the larger of the two thresholds.
  function automatic int unsigned cnt_width(input int unsigned debounce,
                                            input int unsigned long_press);
    int unsigned max_v;
    max_v = (debounce > long_press) ? debounce : long_press;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/oc_button_input_chan.sv
// One button channel: synchronizer, polarity fix, debounce FSM and pulses.
module oc_button_input_chan
  import oc_button_pkg::*;
#(
  parameter int unsigned SyncCycles      = 3,
  parameter int unsigned DebounceCycles  = 1000000,
  parameter int unsigned LongPressCycles = 0,
  parameter bit          ActiveLow       = 1'b0
) (
  input  logic clock,
  input  logic resetN,
  input  logic buttonIn,
  output logic buttonLevel,
  output logic buttonPress,
  output logic buttonRelease,
  output logic buttonLong
);

  localparam int unsigned CntW = cnt_width(DebounceCycles, LongPressCycles);
  localparam logic [CntW-1:0] DebLast  = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LongPressCycles - 1);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [SyncCycles-1:0] SyncIdle = ActiveLow ? '1 : '0;

  if (SyncCycles < 2 || SyncCycles > 4) begin : g_bad_sync
    $error("oc_button_input_chan: SyncCycles out of range");
  end
  if (DebounceCycles < 1) begin : g_bad_deb
    $error("oc_button_input_chan: DebounceCycles must be at least 1");
  end

  logic [SyncCycles-1:0] r_sync;
  logic                  w_sync;
  button_state_e         r_state, w_state_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic                  r_level, w_level_nxt;
  logic                  r_press, w_press_nxt;
  logic                  r_release, w_release_nxt;
  logic                  r_long, w_long_nxt;

  // Synchronizer chain; resets to the pin's released level.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_sync <= SyncIdle;
    else         r_sync <= {r_sync[SyncCycles-2:0], buttonIn};
  end

  assign w_sync = r_sync[SyncCycles-1] ^ ActiveLow;

  // State, counter and registered outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    unique case (r_state)
      ST_RELEASED: begin
        if (w_sync) begin
          if (DebounceCycles == 1) begin
            w_state_nxt = ST_PRESSED;
            w_press_nxt = 1'b1;
            w_level_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_PRESS_PEND;
            w_cnt_nxt   = CntOne;
          end
        end
      end
      ST_PRESS_PEND: begin
        if (!w_sync) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_nxt = ST_PRESSED;
          w_press_nxt = 1'b1;
          w_level_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      ST_PRESSED, ST_HELD_LONG: begin
        if (!w_sync) begin
          if (DebounceCycles == 1) begin
            w_state_nxt   = ST_RELEASED;
            w_release_nxt = 1'b1;
            w_level_nxt   = 1'b0;
            w_cnt_nxt     = '0;
          end else begin
            w_state_nxt = ST_RELEASE_PEND;
            w_cnt_nxt   = CntOne;
          end
        end else if (r_state == ST_PRESSED) begin
          if (LongPressCycles > 0 && r_cnt == LongLast) begin
            w_state_nxt = ST_HELD_LONG;
            w_long_nxt  = 1'b1;
          end else if (r_cnt != CntMax) begin
            w_cnt_nxt = r_cnt + CntOne;
          end
        end
      end
      ST_RELEASE_PEND: begin
        if (w_sync) begin
          // Bounce back: long-press timing starts over.
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_nxt   = ST_RELEASED;
          w_release_nxt = 1'b1;
          w_level_nxt   = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign buttonLevel   = r_level;
  assign buttonPress   = r_press;
  assign buttonRelease = r_release;
  assign buttonLong    = r_long;

endmodule

// File: rtl/oc_button_input.sv
// Multi-channel pushbutton/DIP-switch input conditioner.
module oc_button_input
  import oc_button_pkg::*;
#(
  parameter int unsigned ButtonCount     = 1,
  parameter int unsigned SyncCycles      = 3,
  parameter int unsigned DebounceCycles  = 1000000,
  parameter int unsigned LongPressCycles = 0,
  parameter bit          ActiveLow       = 1'b0
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [ButtonCount-1:0] buttonIn,
  output logic [ButtonCount-1:0] buttonLevel,
  output logic [ButtonCount-1:0] buttonPress,
  output logic [ButtonCount-1:0] buttonRelease,
  output logic [ButtonCount-1:0] buttonLong
);

  if (ButtonCount < 1 || ButtonCount > 16) begin : g_bad_count
    $error("oc_button_input: ButtonCount out of range");
  end

  // Independent, identical channel per pin.
  for (genvar g = 0; g < ButtonCount; g++) begin : g_chan
    oc_button_input_chan #(
      .SyncCycles      (SyncCycles),
      .DebounceCycles  (DebounceCycles),
      .LongPressCycles (LongPressCycles),
      .ActiveLow       (ActiveLow)
    ) u_chan (
      .clock         (clock),
      .resetN        (resetN),
      .buttonIn      (buttonIn[g]),
      .buttonLevel   (buttonLevel[g]),
      .buttonPress   (buttonPress[g]),
      .buttonRelease (buttonRelease[g]),
      .buttonLong    (buttonLong[g])
    );
  end

endmodule

// File: tb/tb_oc_button_input.sv
// Self-checking bench for oc_button_input with a run-length reference model.
module tb_oc_button_input;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pin_a = 4'h0;
  logic [3:0] pin_b = 4'hF;
  logic [1:0] pin_c = 2'h0;

  logic [3:0] lev_a, prs_a, rel_a, lng_a;
  logic [3:0] lev_b, prs_b, rel_b, lng_b;
  logic [1:0] lev_c, prs_c, rel_c, lng_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oc_button_input #(.ButtonCount(4), .SyncCycles(2), .DebounceCycles(8),
                    .LongPressCycles(32), .ActiveLow(1'b0)) u_a (
    .clock(clk), .resetN(rst_n), .buttonIn(pin_a), .buttonLevel(lev_a),
    .buttonPress(prs_a), .buttonRelease(rel_a), .buttonLong(lng_a));

  oc_button_input #(.ButtonCount(4), .SyncCycles(2), .DebounceCycles(8),
                    .LongPressCycles(32), .ActiveLow(1'b1)) u_b (
    .clock(clk), .resetN(rst_n), .buttonIn(pin_b), .buttonLevel(lev_b),
    .buttonPress(prs_b), .buttonRelease(rel_b), .buttonLong(lng_b));

  oc_button_input #(.ButtonCount(2), .SyncCycles(3), .DebounceCycles(1),
                    .LongPressCycles(0), .ActiveLow(1'b0)) u_c (
    .clock(clk), .resetN(rst_n), .buttonIn(pin_c), .buttonLevel(lev_c),
    .buttonPress(prs_c), .buttonRelease(rel_c), .buttonLong(lng_c));

  // Reference: delay line, then count consecutive disagreeing samples.
  typedef struct {
    bit [3:0] q;
    int       m;
    int       h;
    bit       level;
    bit       ldone;
    bit       press;
    bit       rel;
    bit       lng;
  } mdl_t;

  mdl_t mdl_a [4];
  mdl_t mdl_b [4];
  mdl_t mdl_c [2];

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z = '{default: 0};
    return z;
  endfunction

  function automatic mdl_t step(input mdl_t c, input bit pressed_in,
                                input int s_cyc, input int deb, input int lp);
    mdl_t n;
    bit   s;
    n       = c;
    s       = c.q[s_cyc-1];
    n.q     = {c.q[2:0], pressed_in};
    n.press = 1'b0;
    n.rel   = 1'b0;
    n.lng   = 1'b0;
    if (s != c.level) begin
      n.m = c.m + 1;
      if (n.m >= deb) begin
        n.level = s;
        n.press = s;
        n.rel   = !s;
        n.m     = 0;
        n.h     = 0;
        n.ldone = 1'b0;
      end
    end else begin
      if (c.level) begin
        if (c.m > 0) begin
          n.h     = 0;
          n.ldone = 1'b0;
        end else if (!c.ldone) begin
          n.h = c.h + 1;
          if (lp > 0 && n.h == lp) begin
            n.lng   = 1'b1;
            n.ldone = 1'b1;
          end
        end
      end
      n.m = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mdl_a[i] <= mdl_zero();
        mdl_b[i] <= mdl_zero();
      end
      for (int i = 0; i < 2; i++) mdl_c[i] <= mdl_zero();
    end else begin
      for (int i = 0; i < 4; i++) begin
        mdl_a[i] <= step(mdl_a[i], pin_a[i], 2, 8, 32);
        mdl_b[i] <= step(mdl_b[i], !pin_b[i], 2, 8, 32);
      end
      for (int i = 0; i < 2; i++) mdl_c[i] <= step(mdl_c[i], pin_c[i], 3, 1, 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all();
    logic [3:0] el_a, ep_a, er_a, eg_a, el_b, ep_b, er_b, eg_b;
    logic [1:0] el_c, ep_c, er_c, eg_c;
    for (int i = 0; i < 4; i++) begin
      el_a[i] = mdl_a[i].level; ep_a[i] = mdl_a[i].press;
      er_a[i] = mdl_a[i].rel;   eg_a[i] = mdl_a[i].lng;
      el_b[i] = mdl_b[i].level; ep_b[i] = mdl_b[i].press;
      er_b[i] = mdl_b[i].rel;   eg_b[i] = mdl_b[i].lng;
    end
    for (int i = 0; i < 2; i++) begin
      el_c[i] = mdl_c[i].level; ep_c[i] = mdl_c[i].press;
      er_c[i] = mdl_c[i].rel;   eg_c[i] = mdl_c[i].lng;
    end
    chk("a_level", 32'(lev_a), 32'(el_a));
    chk("a_press", 32'(prs_a), 32'(ep_a));
    chk("a_release", 32'(rel_a), 32'(er_a));
    chk("a_long", 32'(lng_a), 32'(eg_a));
    chk("b_level", 32'(lev_b), 32'(el_b));
    chk("b_press", 32'(prs_b), 32'(ep_b));
    chk("b_release", 32'(rel_b), 32'(er_b));
    chk("b_long", 32'(lng_b), 32'(eg_b));
    chk("c_level", 32'(lev_c), 32'(el_c));
    chk("c_press", 32'(prs_c), 32'(ep_c));
    chk("c_release", 32'(rel_c), 32'(er_c));
    chk("c_long", 32'(lng_c), 32'(eg_c));
    chk("a_press_and_release", 32'(prs_a & rel_a), 32'd0);
    chk("a_press_and_long", 32'(prs_a & lng_a), 32'd0);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  // Observation of channel 0 of u_a over a window (1-based cycle index).
  int obs_p, obs_r, obs_l, np, nr, nl, nlev;

  task automatic run_obs(input int n);
    obs_p = 0; obs_r = 0; obs_l = 0; np = 0; nr = 0; nl = 0; nlev = 0;
    for (int k = 1; k <= n; k++) begin
      cyc();
      if (prs_a[0]) begin np++; if (obs_p == 0) obs_p = k; end
      if (rel_a[0]) begin nr++; if (obs_r == 0) obs_r = k; end
      if (lng_a[0]) begin nl++; if (obs_l == 0) obs_l = k; end
      if (lev_a[0]) nlev++;
    end
  endtask

  initial begin
    int acc;
    int first_k;
    logic [3:0] first_v;

    // Reset held with pin high: everything stays quiet.
    rst_n = 1'b0;
    pin_a = 4'b0001;
    pin_b = 4'hF;
    pin_c = 2'b00;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("reset_outputs_zero", 32'({lev_a, prs_a, rel_a, lng_a}), 32'd0);
    end
    rst_n = 1'b1;

    // Held-through-reset press, long press, clean release.
    run_obs(100);
    chk("press_after_reset_cycle", 32'(obs_p), 32'd10);
    chk("press_count", 32'(np), 32'd1);
    chk("long_cycle", 32'(obs_l), 32'd42);
    chk("long_count", 32'(nl), 32'd1);
    chk("level_high_cycles", 32'(nlev), 32'd91);
    chk("no_release_while_held", 32'(nr), 32'd0);
    pin_a = 4'b0000;
    run_obs(40);
    chk("release_cycle", 32'(obs_r), 32'd10);
    chk("release_count", 32'(nr), 32'd1);
    chk("release_no_press", 32'(np + nl), 32'd0);
    chk("level_tail_cycles", 32'(nlev), 32'd9);

    // Glitches shorter than the debounce window.
    acc = 0;
    pin_a = 4'b0001; run_obs(7); acc += np + nr + nl + nlev;
    pin_a = 4'b0000; run_obs(8); acc += np + nr + nl + nlev;
    pin_a = 4'b0001; run_obs(7); acc += np + nr + nl + nlev;
    pin_a = 4'b0000; run_obs(20); acc += np + nr + nl + nlev;
    chk("glitch_no_activity", 32'(acc), 32'd0);

    // Release bounce restarts the long timer.
    pin_a = 4'b0001; run_obs(30);
    chk("bounce_press_cycle", 32'(obs_p), 32'd10);
    pin_a = 4'b0000; run_obs(5);
    chk("bounce_no_release", 32'(nr + np + nl), 32'd0);
    pin_a = 4'b0001; run_obs(60);
    chk("bounce_long_cycle", 32'(obs_l), 32'd35);
    chk("bounce_long_count", 32'(nl), 32'd1);
    chk("bounce_no_events", 32'(nr + np), 32'd0);
    pin_a = 4'b0000; run_obs(20);
    chk("bounce_final_release", 32'(nr), 32'd1);

    // Active-low channels 0 and 2 pressed together.
    pin_b = 4'b1010;
    first_k = 0;
    first_v = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (prs_b != 4'h0 && first_k == 0) begin
        first_k = k;
        first_v = prs_b;
      end
    end
    chk("multi_press_cycle", 32'(first_k), 32'd10);
    chk("multi_press_vector", 32'(first_v), 32'h5);
    chk("multi_level", 32'(lev_b), 32'h5);
    pin_b = 4'hF;
    for (int k = 0; k < 20; k++) cyc();

    // Single-cycle debounce: latency is sync depth plus one.
    pin_c = 2'b01;
    first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (prs_c[0] && first_k == 0) first_k = k;
    end
    chk("deb1_press_cycle", 32'(first_k), 32'd4);
    pin_c = 2'b00;
    first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (rel_c[0] && first_k == 0) first_k = k;
    end
    chk("deb1_release_cycle", 32'(first_k), 32'd4);

    // Randomized pins on all instances against the model.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(15) == 0) pin_a[i] = ~pin_a[i];
        if ($urandom_range(15) == 0) pin_b[i] = ~pin_b[i];
      end
      for (int i = 0; i < 2; i++)
        if ($urandom_range(2) == 0) pin_c[i] = ~pin_c[i];
      cyc();
    end

    // Settle, then press and reset mid-PRESSED.
    pin_a = 4'b0000; pin_b = 4'hF; pin_c = 2'b00;
    for (int k = 0; k < 20; k++) cyc();
    pin_a = 4'b0001;
    run_obs(15);
    chk("pre_reset_level", 32'(lev_a[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_level", 32'(lev_a), 32'd0);
    chk("async_reset_release", 32'(rel_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("reset_no_release", 32'(rel_a), 32'd0);
    end
    rst_n = 1'b1;
    run_obs(20);
    chk("fresh_press_cycle", 32'(obs_p), 32'd10);
    chk("fresh_press_no_release", 32'(nr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
